// File: rtl/see_merge_pkg.sv
// Shared defaults, payload type and round-robin helper for the see_merge concentrator.
package see_merge_package;

    localparam int unsigned NumChDefault = 3;
    localparam int unsigned DataWDefault = 32;
    localparam int unsigned DepthDefault = 4;

    typedef logic [DataWDefault-1:0] see_data_t;

    // First requester strictly after last, ascending with wrap over n channels (n <= 16).
    // Returns last itself when nothing requests; callers gate with |req.
    function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last,
                                           input int unsigned n);
        logic [3:0]  res;
        logic        found;
        int unsigned idx;
        res   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= 16; k++) begin
            idx = 32'(last) + k;
            if (idx >= n) idx = idx - n;
            if (k <= n && !found && req[idx[3:0]]) begin
                found = 1'b1;
                res   = idx[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/see_merge_fifo.sv
// Single-channel synchronous FIFO with occupancy count; push is ignored when full.
module see_fifo #(
    parameter int unsigned  DATA_W = 32,
    parameter int unsigned  DEPTH  = 4,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic [LVL_W-1:0]  level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & (level_q != '0);
    assign head_o  = mem_q[rd_q];
    assign level_o = level_q;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) wr_d = wr_q + PTR_W'(1);
        if (do_pop)  rd_d = rd_q + PTR_W'(1);
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/see_merge.sv
// N-channel ready/valid concentrator: per-channel FIFOs drained round-robin into one
// registered output tagged with its source channel.
module see_merge
    import see_merge_package::*;
#(
    parameter int unsigned  NUM_CH = NumChDefault,
    parameter int unsigned  DATA_W = DataWDefault,
    parameter int unsigned  DEPTH  = DepthDefault,
    localparam int unsigned CH_W   = $clog2(NUM_CH),
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH-1:0]             see_vld,
    output logic [NUM_CH-1:0]             see_rdy,
    input  logic [NUM_CH-1:0][DATA_W-1:0] see_data,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [DATA_W-1:0]             out_data,
    output logic [CH_W-1:0]               out_ch,
    output logic [NUM_CH-1:0][LVL_W-1:0]  ch_level
);

    logic [NUM_CH-1:0]             full, push, pop, req;
    logic [NUM_CH-1:0][DATA_W-1:0] head;
    logic                          load;
    logic [CH_W-1:0]               grant;
    logic [CH_W-1:0]               last_grant_q, last_grant_d;
    logic                          out_vld_q, out_vld_d;
    logic [DATA_W-1:0]             out_data_q, out_data_d;
    logic [CH_W-1:0]               out_ch_q, out_ch_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Ready looks only at the registered level, never at this cycle's pop.
        assign see_rdy[i] = ch_en[i] & ~full[i];
        assign push[i]    = see_vld[i] & see_rdy[i];
        assign req[i]     = ch_en[i] & (ch_level[i] != '0);

        see_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .wdata_i (see_data[i]),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .level_o (ch_level[i])
        );
    end

    assign load = ~out_vld_q | out_rdy;

    always_comb begin
        grant        = CH_W'(rr_next(16'(req), 4'(last_grant_q), NUM_CH));
        pop          = '0;
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (|req) begin
                pop[grant]   = 1'b1;
                out_vld_d    = 1'b1;
                out_data_d   = head[grant];
                out_ch_d     = grant;
                last_grant_d = grant;
            end else begin
                out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_ch   = out_ch_q;

endmodule

// File: tb/tb_see_merge.sv
// Self-checking bench for see_merge: directed vector table, corner sequences and a
// queue-based reference model run against randomized traffic.
module tb_see_merge;

    localparam int unsigned NCH = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 4;
    localparam int unsigned LW  = 3;
    localparam int unsigned CW  = 2;

    typedef logic [DW-1:0] word_t;

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] vld;
        word_t          d;
        logic           rdy;
        logic           evld;
        word_t          edata;
        logic [CW-1:0]  ech;
        logic [8:0]     elvl;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic [NCH-1:0]             ch_en, see_vld, see_rdy;
    logic [NCH-1:0][DW-1:0]     see_data;
    logic                       out_vld, out_rdy;
    logic [DW-1:0]              out_data;
    logic [CW-1:0]              out_ch;
    logic [NCH-1:0][LW-1:0]     ch_level;

    see_merge #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .DEPTH  (DEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_en    (ch_en),
        .see_vld  (see_vld),
        .see_rdy  (see_rdy),
        .see_data (see_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_ch   (out_ch),
        .ch_level (ch_level)
    );

    int    checks = 0;
    int    errors = 0;

    // Reference model state
    word_t mq[NCH][$];
    logic  m_vld;
    word_t m_data;
    int    m_ch;
    int    m_last;

    // Observed DUT traffic
    int    n_push;
    int    d_ch[$];
    word_t d_data[$];

    vec_t  vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit req[NCH];
        bit acc[NCH];
        bit load;
        if (rst) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            m_vld  = 1'b0;
            m_data = '0;
            m_ch   = 0;
            m_last = NCH - 1;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            acc[i] = ch_en[i] && see_vld[i] && (mq[i].size() < DEP);
            req[i] = ch_en[i] && (mq[i].size() > 0);
        end
        load = !m_vld || out_rdy;
        if (load) begin
            m_vld = 1'b0;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (req[c]) begin
                    m_vld  = 1'b1;
                    m_ch   = c;
                    m_last = c;
                    m_data = mq[c].pop_front();
                    break;
                end
            end
        end
        for (int i = 0; i < NCH; i++) if (acc[i]) mq[i].push_back(see_data[i]);
    endtask

    task automatic tick();
        logic [NCH-1:0] er;
        if (out_vld && out_rdy && !rst) begin
            d_ch.push_back(int'(out_ch));
            d_data.push_back(out_data);
        end
        if (!rst) n_push += $countones(see_vld & see_rdy);
        @(posedge clk);
        model_edge();
        #1;
        chk("out_vld", out_vld, m_vld);
        if (m_vld) begin
            chk("out_data", out_data, m_data);
            chk("out_ch", out_ch, m_ch);
        end
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("ch_level[%0d]", i), ch_level[i], mq[i].size());
            er[i] = ch_en[i] && (mq[i].size() < DEP);
        end
        chk("see_rdy", see_rdy, er);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        see_vld = '0;
        tick();
        rst     = 1'b0;
    endtask

    task automatic set_data(input word_t base);
        for (int c = 0; c < NCH; c++) see_data[c] = base ^ word_t'(c);
    endtask

    // Push 'n' words into every channel with the output stalled.
    task automatic preload(input int n);
        out_rdy = 1'b0;
        see_vld = '1;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < NCH; c++) see_data[c] = word_t'(200 + 16 * c + k);
            tick();
        end
        see_vld = '0;
    endtask

    initial begin
        rst      = 1'b0;
        ch_en    = '1;
        see_vld  = '0;
        see_data = '0;
        out_rdy  = 1'b1;
        n_push   = 0;

        vt[0]  = '{3'h7, 3'h2, 32'hA4, 1'b1, 1'b0, 32'h00, 2'd0, 9'o010};
        vt[1]  = '{3'h7, 3'h0, 32'h00, 1'b1, 1'b1, 32'hA5, 2'd1, 9'o000};
        vt[2]  = '{3'h7, 3'h0, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 9'o000};
        vt[3]  = '{3'h7, 3'h5, 32'h20, 1'b1, 1'b0, 32'h00, 2'd0, 9'o101};
        vt[4]  = '{3'h7, 3'h0, 32'h00, 1'b1, 1'b1, 32'h22, 2'd2, 9'o001};
        vt[5]  = '{3'h7, 3'h0, 32'h00, 1'b1, 1'b1, 32'h20, 2'd0, 9'o000};
        vt[6]  = '{3'h7, 3'h0, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 9'o000};
        vt[7]  = '{3'h7, 3'h1, 32'h30, 1'b0, 1'b0, 32'h00, 2'd0, 9'o001};
        vt[8]  = '{3'h7, 3'h0, 32'h00, 1'b0, 1'b1, 32'h30, 2'd0, 9'o000};
        vt[9]  = '{3'h7, 3'h2, 32'h40, 1'b0, 1'b1, 32'h30, 2'd0, 9'o010};
        vt[10] = '{3'h7, 3'h0, 32'h00, 1'b1, 1'b1, 32'h41, 2'd1, 9'o000};
        vt[11] = '{3'h7, 3'h0, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 9'o000};

        // Reset state
        do_reset();
        chk("rst out_vld", out_vld, 1'b0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst out_ch", out_ch, 2'd0);
        chk("rst ch_level", ch_level, 9'o000);
        chk("rst see_rdy", see_rdy, 3'h7);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            ch_en   = vt[i].en;
            see_vld = vt[i].vld;
            set_data(vt[i].d);
            out_rdy = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d out_vld", i), out_vld, vt[i].evld);
            if (vt[i].evld) begin
                chk($sformatf("vec%0d out_data", i), out_data, vt[i].edata);
                chk($sformatf("vec%0d out_ch", i), out_ch, vt[i].ech);
            end
            chk($sformatf("vec%0d ch_level", i), ch_level, vt[i].elvl);
        end

        // Fill: 4 in FIFO + 1 in output register, then drain in order
        ch_en   = '1;
        out_rdy = 1'b0;
        do_reset();
        n_push  = 0;
        see_vld = 3'b001;
        for (int k = 0; k < 8; k++) begin
            see_data[0] = word_t'(100 + k);
            tick();
        end
        chk("fill accepted", n_push, 5);
        chk("fill see_rdy0", see_rdy[0], 1'b0);
        chk("fill level0", ch_level[0], 4);
        see_vld = '0;
        out_rdy = 1'b1;
        d_data.delete();
        for (int k = 0; k < 7; k++) tick();
        chk("fill drained", d_data.size(), 5);
        for (int i = 0; i < d_data.size(); i++) chk("fill order", d_data[i], 100 + i);

        // Fairness: back-to-back 0,1,2,... with no gaps
        do_reset();
        preload(4);
        out_rdy = 1'b1;
        d_ch.delete();
        for (int k = 0; k < 12; k++) tick();
        chk("fair count", d_ch.size(), 12);
        for (int i = 0; i < d_ch.size(); i++) chk("fair seq", d_ch[i], i % 3);

        // Backpressure: toggled out_rdy, held output stable, every word exactly once
        do_reset();
        preload(4);
        d_data.delete();
        for (int k = 0; k < 30; k++) begin
            logic  hold;
            word_t pd;
            logic [CW-1:0] pc;
            out_rdy = k[0];
            hold    = out_vld && !out_rdy;
            pd      = out_data;
            pc      = out_ch;
            tick();
            if (hold) begin
                chk("bp data stable", out_data, pd);
                chk("bp ch stable", out_ch, pc);
            end
        end
        chk("bp count", d_data.size(), 12);
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 4; k++) begin
                int n;
                n = 0;
                foreach (d_data[j]) if (d_data[j] == word_t'(200 + 16 * c + k)) n++;
                chk($sformatf("bp once %0d/%0d", c, k), n, 1);
            end
        end

        // Enable: disabled channel skipped and not ready, then resumes in order
        do_reset();
        preload(4);
        ch_en   = 3'b101;
        out_rdy = 1'b1;
        d_ch.delete();
        d_data.delete();
        tick();
        chk("en see_rdy1", see_rdy[1], 1'b0);
        for (int k = 0; k < 10; k++) tick();
        begin
            int n1;
            n1 = 0;
            foreach (d_ch[j]) if (d_ch[j] == 1) n1++;
            chk("en skipped", n1, 0);
        end
        chk("en level1 kept", ch_level[1], 4);
        ch_en = '1;
        d_data.delete();
        for (int k = 0; k < 6; k++) tick();
        chk("en resumed", d_data.size(), 4);
        for (int i = 0; i < d_data.size(); i++) chk("en order", d_data[i], 216 + i);

        // Reset mid-stream with coincident pushes
        do_reset();
        preload(2);
        rst     = 1'b1;
        see_vld = '1;
        tick();
        rst     = 1'b0;
        see_vld = '0;
        chk("mid out_vld", out_vld, 1'b0);
        chk("mid ch_level", ch_level, 9'o000);
        see_vld = '1;
        set_data(32'h500);
        out_rdy = 1'b1;
        tick();
        see_vld = '0;
        d_ch.delete();
        for (int k = 0; k < 4; k++) tick();
        chk("mid xfers", d_ch.size(), 3);
        if (d_ch.size() > 0) chk("mid first grant", d_ch[0], 0);

        // Randomized traffic against the model
        ch_en = '1;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 31) == 0) ch_en = NCH'($urandom);
            see_vld = NCH'($urandom);
            for (int c = 0; c < NCH; c++) see_data[c] = $urandom;
            out_rdy = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst     = 1'b0;
        ch_en   = '1;
        see_vld = '0;
        out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("final drained", out_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/see_merge.md
# see_merge

Parametrised N-channel ready/valid concentrator. Each of NUM_CH "see" sink channels feeds its own DEPTH-entry FIFO. A round-robin arbiter drains the FIFOs into one registered ready/valid output tagged with the source channel. It replaces fixed fan-in of independent per-channel sinks and sits ahead of a single shared downstream consumer.

## Interface
Parameters:
- NUM_CH, 3: number of input channels, 2..16.
- DATA_W, 32: payload width.
- DEPTH, 4: per-channel FIFO entries; power of two, 2..64.
- CH_W, $clog2(NUM_CH): channel-ID width, derived, not overridden.
- LVL_W, $clog2(DEPTH+1): occupancy width, derived.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- ch_en  in  NUM_CH  per-channel enable mask.
- see_vld  in  NUM_CH  per-channel valid.
- see_rdy  out  NUM_CH  per-channel ready.
- see_data  in  NUM_CH x DATA_W  per-channel payload.
- out_vld  out  1  output valid.
- out_rdy  in  1  downstream ready.
- out_data  out  DATA_W  output payload.
- out_ch  out  CH_W  source channel of out_data.
- ch_level  out  NUM_CH x LVL_W  per-channel FIFO occupancy.

## Operation
- Transfer on any port occurs when vld & rdy are both high at the rising edge.
- see_rdy[i] = ch_en[i] & (level[i] != DEPTH).
- see_rdy[i] never depends on a same-cycle pop, so a full FIFO does not accept a word even when it is popped that cycle.
- A disabled channel keeps its FIFO contents, is never granted, and holds see_rdy low. Re-enabling resumes in order.
- Request[i] = ch_en[i] & (level[i] != 0).
- Output register load condition: !out_vld | out_rdy. Requests are ignored in a cycle where this condition is false.
- When loading with any request active, the arbiter grants the first requesting channel strictly after last_grant, in ascending index with wrap. That channel's head is popped into out_data/out_ch, out_vld is set, and last_grant is updated.
- When loading with no request active, out_vld clears.
- While out_vld & !out_rdy, out_data and out_ch are held stable and no pop occurs.
- Per-channel order is preserved. Data is never dropped or duplicated.
- Simultaneous push and pop on one channel leaves level unchanged.
- FIFO pointers are log2(DEPTH) bits, wrap modulo DEPTH. Level counts 0..DEPTH.

## Timing
- Reset values:
  - out_vld = 0, out_data = 0, out_ch = 0.
  - All levels and pointers = 0; see_rdy follows ch_en (all FIFOs empty).
  - last_grant = NUM_CH-1, so channel 0 wins first.
- Reset mid-operation discards all buffered data and the output register in the same cycle. Any input handshake coincident with rst is ignored.
- Latency: a word accepted at edge N shows level +1 after edge N. With the output idle, out_vld is high after edge N+1 (2 cycles).
- Throughput: one output per cycle while out_rdy is held high and a request exists.
- Fairness: with all NUM_CH channels continuously requesting, each channel receives exactly one grant in every NUM_CH consecutive output transfers.

## Structure
- Shared package see_merge_package holds:
  - defaults for NUM_CH, DATA_W and DEPTH;
  - typedef see_data_t (logic [DATA_W-1:0]);
  - a function computing the round-robin next grant from a request vector and last_grant.
- Sub-module see_fifo is a single-channel synchronous FIFO parametrised on DATA_W and DEPTH, with push, pop, head, full and level. see_merge generates NUM_CH instances of it.
- Arbiter and output register live in see_merge.

## Test plan
- Single word 0xA5 on channel 1 only, out_rdy high: out_vld after 2 cycles, out_data=0xA5, out_ch=1; level[1] returns to 0.
- Fill: out_rdy low, channel 0 pushes continuously.
  - Required: see_rdy[0] drops after 4 words accepted into the FIFO (level[0]=4) plus 1 word in the output register.
  - Required: no further acceptances.
  - Then raise out_rdy: 5 words drain in order.
- Fairness: all 3 channels preloaded with 4 words, out_rdy high → out_ch sequence 0,1,2,0,1,2,…, with no gaps.
- Backpressure: toggle out_rdy every cycle → out_data/out_ch stable while stalled; every word appears exactly once.
- Enable: clear ch_en[1] with data buffered → channel 1 is skipped and see_rdy[1]=0. Re-enable → its buffered words emerge in order.
- Reset mid-stream with all FIFOs partially full → next cycle out_vld=0, all ch_level=0, and the first post-reset grant goes to channel 0.
